// File: rtl/mem_stage_sram_unit_pkg.sv
// Shared widths, SRAM constants and FSM encodings for the
// memory stage and its MEM/WB register.
package mem_stage_sram_unit_pkg;

   localparam int REGISTER_FILE_LEN         = 32;
   localparam int REGISTER_FILE_ADDRESS_LEN = 4;
   localparam int SRAM_DATA_LEN             = 16;
   localparam int SRAM_ADDR_LEN             = 18;
   localparam int MEM_BASE_ADDR             = 1024;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOW  = 2'd1;
   localparam logic [1:0] S_HIGH = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   typedef struct packed {
      logic                                 wb_en;
      logic                                 mem_r_en;
      logic [REGISTER_FILE_LEN-1:0]         alu_res;
      logic [REGISTER_FILE_LEN-1:0]         mem_data;
      logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest;
   } mem_wb_t;

endpackage

// File: rtl/mem_stage_sram_unit_mem_wb_stage_reg.sv
// MEM/WB pipeline register: synchronous reset, load enable.
// Holds its contents while the memory stage stalls.
module mem_wb_stage_reg
   import mem_stage_sram_unit_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    i_ld,
   input  mem_wb_t i_d,
   output mem_wb_t o_q
);

   mem_wb_t r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_ld) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/mem_stage_sram_unit.sv
// Memory stage: 32-bit loads/stores over a 16-bit wait-stated
// SRAM, two halfword phases, pipeline stalled via ready.
module mem_stage_sram_unit
   import mem_stage_sram_unit_pkg::*;
#(
   parameter int SRAM_ADDR_W = SRAM_ADDR_LEN,
   parameter int WAIT_CYCLES = 2,
   parameter int MEM_BASE    = MEM_BASE_ADDR
)
(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 wb_en_in,
   input  logic                                 mem_r_en_in,
   input  logic                                 mem_w_en_in,
   input  logic [REGISTER_FILE_LEN-1:0]         alu_res_in,
   input  logic [REGISTER_FILE_LEN-1:0]         val_r_m_in,
   input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_in,
   output logic                                 ready,
   output logic                                 wb_en_out,
   output logic                                 mem_r_en_out,
   output logic [REGISTER_FILE_LEN-1:0]         alu_res_out,
   output logic [REGISTER_FILE_LEN-1:0]         mem_data_out,
   output logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_out,
   output logic [SRAM_ADDR_W-1:0]               sram_addr,
   output logic [SRAM_DATA_LEN-1:0]             sram_wdata,
   input  logic [SRAM_DATA_LEN-1:0]             sram_rdata,
   output logic                                 sram_we_n
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   logic [1:0]                   r_state;
   logic [CNT_W-1:0]             r_cnt;
   logic [SRAM_ADDR_W-2:0]       r_word;
   logic [REGISTER_FILE_LEN-1:0] r_wdata;
   logic                         r_is_w;
   logic [SRAM_DATA_LEN-1:0]     r_rd_lo;
   logic [SRAM_DATA_LEN-1:0]     r_rd_hi;

   logic                   w_req;
   logic                   w_last;
   logic                   w_phase;
   logic                   w_hi;
   logic [SRAM_ADDR_W-2:0] w_word;
   mem_wb_t                w_d;
   mem_wb_t                w_q;

   assign w_req   = mem_r_en_in | mem_w_en_in;
   assign w_last  = (r_cnt == CNT_LAST);
   assign w_hi    = (r_state == S_HIGH);
   assign w_phase = (r_state == S_LOW) | w_hi;
   assign w_word  = (SRAM_ADDR_W-1)'((alu_res_in - 32'(MEM_BASE)) >> 2);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_word  <= '0;
         r_wdata <= '0;
         r_is_w  <= 1'b0;
         r_rd_lo <= '0;
         r_rd_hi <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_req) begin
                  r_word  <= w_word;
                  r_wdata <= val_r_m_in;
                  r_is_w  <= mem_w_en_in;
                  r_state <= S_LOW;
               end
            end
            S_LOW: begin
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= S_HIGH;
                  if (!r_is_w) r_rd_lo <= sram_rdata;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_HIGH: begin
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= S_DONE;
                  if (!r_is_w) r_rd_hi <= sram_rdata;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Strobe and data are driven only while a store phase is active
   assign sram_addr  = w_phase ? {r_word, w_hi} : '0;
   assign sram_we_n  = ~(w_phase & r_is_w);
   assign sram_wdata = (w_phase & r_is_w)
                     ? (w_hi ? r_wdata[31:16] : r_wdata[15:0])
                     : '0;

   assign ready = (r_state == S_DONE)
                | ((r_state == S_IDLE) & ~w_req);

   assign w_d.wb_en    = wb_en_in;
   assign w_d.mem_r_en = mem_r_en_in;
   assign w_d.alu_res  = alu_res_in;
   assign w_d.mem_data = {r_rd_hi, r_rd_lo};
   assign w_d.dest     = dest_in;

   mem_wb_stage_reg u_mem_wb (
      .clk  (clk),
      .rst  (rst),
      .i_ld (ready),
      .i_d  (w_d),
      .o_q  (w_q)
   );

   assign wb_en_out    = w_q.wb_en;
   assign mem_r_en_out = w_q.mem_r_en;
   assign alu_res_out  = w_q.alu_res;
   assign mem_data_out = w_q.mem_data;
   assign dest_out     = w_q.dest;

endmodule

// File: doc/mem_stage_sram_unit.md
# mem_stage_sram_unit

Memory stage of the pipelined ARM core. It consumes the EXE/MEM pipeline register outputs and, for loads and stores, performs a 32-bit access to an external SRAM through a 16-bit, multi-cycle, wait-stated interface. While an access is in progress it stalls the pipeline through `ready`. Its internal MEM/WB register feeds the write-back stage and the `wb_wb_val` forwarding path.

## Interface
Parameters:
- `SRAM_ADDR_W`, 18: SRAM halfword address width.
- `WAIT_CYCLES`, 2: cycles per halfword access (≥1).
- `MEM_BASE`, 1024: byte address mapped to SRAM halfword 0.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wb_en_in` in 1: write-back enable from EXE/MEM register.
- `mem_r_en_in` in 1: load request.
- `mem_w_en_in` in 1: store request.
- `alu_res_in` in `REGISTER_FILE_LEN`: byte address for memory ops, or the result for ALU ops.
- `val_r_m_in` in `REGISTER_FILE_LEN`: store data.
- `dest_in` in `REGISTER_FILE_ADDRESS_LEN`: destination register.
- `ready` out 1: high = MEM stage completes this cycle; low = freeze all upstream stages.
- `wb_en_out`, `mem_r_en_out` out 1: registered control signals to WB.
- `alu_res_out`, `mem_data_out` out `REGISTER_FILE_LEN`: registered ALU result and load data.
- `dest_out` out `REGISTER_FILE_ADDRESS_LEN`: registered destination.
- `sram_addr` out `SRAM_ADDR_W`: halfword address.
- `sram_wdata` out 16: write data.
- `sram_rdata` in 16: read data; valid by the last cycle of each phase.
- `sram_we_n` out 1: active-low write strobe.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE.
- **IDLE**
  - If `mem_w_en_in | mem_r_en_in`: latch address, store data and op, then go to LOW. A store takes priority if both enables are high.
  - Otherwise stay in IDLE.
- **LOW**: access halfword `{word_addr, 1'b0}` for `WAIT_CYCLES` cycles, using an internal counter that restarts at each phase. Then go to HIGH.
- **HIGH**: access halfword `{word_addr, 1'b1}` for `WAIT_CYCLES` cycles, then go to DONE.
- **DONE**: one cycle, then go to IDLE.
- Address: `word_addr = ((alu_res_in - MEM_BASE) >> 2)`, truncated to `SRAM_ADDR_W-1` bits. `alu_res_in[1:0]` is ignored.
- Store:
  - LOW phase drives `sram_wdata = val_r_m[15:0]`; HIGH phase drives `val_r_m[31:16]`.
  - `sram_we_n = 0` for every cycle of both phases.
  - Address and data stay stable for the whole phase.
- Load:
  - `sram_we_n = 1`.
  - `sram_rdata` is captured on the last cycle of LOW into `rd_lo`, and on the last cycle of HIGH into `rd_hi`.
- Outside LOW and HIGH: `sram_addr = 0`, `sram_wdata = 0`, `sram_we_n = 1`.
- `ready` is combinational: `(state==DONE) | (state==IDLE & ~mem_r_en_in & ~mem_w_en_in)`.
- MEM/WB register:
  - Loads `wb_en_in`, `mem_r_en_in`, `alu_res_in`, `{rd_hi, rd_lo}` and `dest_in` when `ready=1`.
  - Holds its value when `ready=0`. A repeated write-back of the held instruction is harmless.
  - For loads, `mem_data_out` takes `{rd_hi, rd_lo}` as captured by the end of HIGH.
  - For non-loads, `mem_data_out` is don't-care; it is implemented as the last assembled value.

## Timing
- Reset values: all registered outputs 0; state IDLE; `sram_we_n = 1`; `sram_addr = 0`; `sram_wdata = 0`; `ready = 1` when no request is present.
- Non-memory instruction: zero stall; results appear on outputs one cycle after presentation.
- Memory instruction: occupies `2*WAIT_CYCLES + 2` cycles.
  - `ready` is low for `2*WAIT_CYCLES + 1` cycles (IDLE detect, LOW, HIGH) and high in DONE.
  - Outputs update at the DONE clock edge.
  - With the default `WAIT_CYCLES = 2`: 5 stall cycles, 6 cycles in total.
- Back-to-back memory ops: the next instruction reaches the inputs at the DONE edge. IDLE detects it the following cycle; no request is lost and no extra idle cycle is inserted.
- Inputs are held stable by the upstream freeze while `ready = 0`. The block still latches address and data at IDLE→LOW.
- `rst` in any state: next cycle is IDLE with all reset values. An in-flight store may leave the SRAM partially written; this is accepted.

## Structure
- `Constants.v` adds SRAM constants (`SRAM_DATA_LEN` = 16, `SRAM_ADDR_LEN` = 18, `MEM_BASE_ADDR` = 1024) and the 2-bit FSM state encodings.
- Sub-module `mem_wb_stage_reg`: a resettable register with load enable for the MEM/WB fields.
- The FSM, counter and address/data path stay in the top level.

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-run → all outputs 0, `sram_we_n = 1`, `ready = 1`.
- **ALU passthrough:** `alu_res_in = 0x55`, `wb_en_in = 1`, `dest_in = 3`, no memory op → `ready` stays 1; next cycle `alu_res_out = 0x55`, `dest_out = 3`; no SRAM activity.
- **Store:** `alu_res_in = 1032`, `val_r_m_in = 0xDEADBEEF`, `mem_w_en_in = 1` → `ready = 0` for 5 cycles.
  - `sram_addr = 4`, `sram_wdata = 0xBEEF`, `we_n = 0` for 2 cycles.
  - Then `sram_addr = 5`, `sram_wdata = 0xDEAD` for 2 cycles.
  - `ready = 1` on cycle 6.
- **Load:** load from 1032 with the SRAM model holding the stored value → after `ready = 1`, next cycle `mem_data_out = 0xDEADBEEF`, `mem_r_en_out = 1`.
- **Back-to-back:** a load immediately followed by a store to 1036 → the second access starts on the cycle after DONE at `sram_addr = 6`; total 12 cycles.
- **Reset mid-access:** assert `rst` during HIGH of a store → next cycle IDLE, `sram_we_n = 1`, outputs 0, `ready = 1` when no request is present.
